// File: rtl/ula_seq.sv
// ula_seq: registered ALU with a START/DONE handshake.
// MUL (shift-add) and DIV (restoring) iterate over WIDTH cycles; every other op completes in one cycle.
module ula_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    output logic [WIDTH-1:0] RESULTADO,
    output logic [WIDTH-1:0] RESTOdiv,
    output logic             ZERO,
    output logic             DIV0,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned AW = 2 * WIDTH;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SGT  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNEQ = 4'b1011;
    localparam logic [3:0] OP_SR   = 4'b1100;
    localparam logic [3:0] OP_SL   = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;      // MUL: {high, low} product; DIV: {remainder, quotient}
    logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             zero_q, zero_d;
    logic             div0_q, div0_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] alu_rem;
    logic             alu_zero;
    logic             alu_div0;

    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_next;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [AW-1:0]    div_next;

    // Single-cycle operations, including the divide-by-zero response
    always_comb begin
        alu_res  = '0;
        alu_rem  = '0;
        alu_zero = 1'b0;
        alu_div0 = 1'b0;
        case (ALUop)
            OP_ADD:  alu_res = D1 + D2;
            OP_SUB:  alu_res = D1 - D2;
            OP_DIV: begin
                alu_res  = '1;
                alu_rem  = D1;
                alu_div0 = 1'b1;
            end
            OP_NOT:  alu_res = ~D1;
            OP_AND:  alu_res = D1 & D2;
            OP_OR:   alu_res = D1 | D2;
            OP_XOR:  alu_res = D1 ^ D2;
            OP_SLT:  alu_res = WIDTH'(D1 < D2);
            OP_SGT:  alu_res = WIDTH'(D1 > D2);
            OP_BEQ:  alu_zero = (D1 == D2);
            OP_BNEQ: alu_zero = (D1 != D2);
            OP_SR:   alu_res = D1 >> 1;
            OP_SL:   alu_res = D1 << 1;
            default: ;
        endcase
    end

    // One shift-add step: add multiplicand to the high half if the low bit is set, then shift right
    always_comb begin
        mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[AW-1:1]};
    end

    // One restoring step: shift {rem, quo} left, subtract divisor if it fits, shift in the quotient bit
    always_comb begin
        div_ge   = acc_q[AW-1:WIDTH-1] >= {1'b0, opnd_q};
        div_sub  = acc_q[AW-2:WIDTH-1] - opnd_q;
        div_next = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                          : {acc_q[AW-2:0], 1'b0};
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        rem_d   = rem_q;
        zero_d  = zero_q;
        div0_d  = div0_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (ALUop == OP_MUL || (ALUop == OP_DIV && D2 != '0)) begin
                        state_d = (ALUop == OP_MUL) ? S_MUL : S_DIV;
                        acc_d   = {{WIDTH{1'b0}}, D1};
                        opnd_d  = D2;
                        cnt_d   = CW'(WIDTH);
                        busy_d  = 1'b1;
                    end else begin
                        res_d  = alu_res;
                        rem_d  = alu_rem;
                        zero_d = alu_zero;
                        div0_d = alu_div0;
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q != '0) begin
                    acc_d = (state_q == S_MUL) ? mul_next : div_next;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_d   = acc_q[WIDTH-1:0];
                    rem_d   = acc_q[AW-1:WIDTH];
                    zero_d  = 1'b0;
                    div0_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            zero_q  <= 1'b0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            zero_q  <= zero_d;
            div0_q  <= div0_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign RESULTADO = res_q;
    assign RESTOdiv  = rem_q;
    assign ZERO      = zero_q;
    assign DIV0      = div0_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: a 32-bit and an 8-bit instance against an arithmetic reference model.
module tb_ula_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start32, start8;
    logic [3:0]  op32, op8;
    logic [31:0] a32, b32, res32, rem32;
    logic [7:0]  a8, b8, res8, rem8;
    logic        z32, d032, busy32, done32;
    logic        z8, d08, busy8, done8;

    ula_seq #(.WIDTH(32)) u32 (
        .CLK(clk), .RST_N(rst_n), .START(start32), .ALUop(op32), .D1(a32), .D2(b32),
        .RESULTADO(res32), .RESTOdiv(rem32), .ZERO(z32), .DIV0(d032), .BUSY(busy32), .DONE(done32)
    );

    ula_seq #(.WIDTH(8)) u8 (
        .CLK(clk), .RST_N(rst_n), .START(start8), .ALUop(op8), .D1(a8), .D2(b8),
        .RESULTADO(res8), .RESTOdiv(rem8), .ZERO(z8), .DIV0(d08), .BUSY(busy8), .DONE(done8)
    );

    typedef struct {
        int              inst;
        longint unsigned res;
        longint unsigned rem;
        bit              z;
        bit              d0;
        bit              multi;
        longint          start_edge;
        longint          done_edge;
    } exp_t;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;
    int     widths[2] = '{32, 8};

    logic [63:0] m_res[2];
    logic [63:0] m_rem[2];
    logic        m_z[2], m_d0[2], m_busy[2], m_done[2];
    logic [63:0] lst_res[2];
    logic [63:0] lst_rem[2];
    logic [1:0]  lst_flags[2];

    assign m_res[0]  = 64'(res32);
    assign m_res[1]  = 64'(res8);
    assign m_rem[0]  = 64'(rem32);
    assign m_rem[1]  = 64'(rem8);
    assign m_z[0]    = z32;
    assign m_z[1]    = z8;
    assign m_d0[0]   = d032;
    assign m_d0[1]   = d08;
    assign m_busy[0] = busy32;
    assign m_busy[1] = busy8;
    assign m_done[0] = done32;
    assign m_done[1] = done8;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain arithmetic on 64-bit integers, masked to the operand width
    function automatic void ref_model(input int w, input logic [3:0] op,
                                      input longint unsigned a, input longint unsigned b,
                                      output exp_t e);
        longint unsigned mask;
        longint unsigned p;
        mask    = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        e.inst  = 0;
        e.res   = 0;
        e.rem   = 0;
        e.z     = 1'b0;
        e.d0    = 1'b0;
        e.multi = 1'b0;
        e.start_edge = 0;
        e.done_edge  = 0;
        case (op)
            4'd0:  e.res = (a + b) & mask;
            4'd1:  e.res = (a - b) & mask;
            4'd2: begin
                p       = a * b;
                e.res   = p & mask;
                e.rem   = p >> w;
                e.multi = 1'b1;
            end
            4'd3: begin
                if (b == 0) begin
                    e.res = mask;
                    e.rem = a;
                    e.d0  = 1'b1;
                end else begin
                    e.res   = a / b;
                    e.rem   = a % b;
                    e.multi = 1'b1;
                end
            end
            4'd4:  e.res = ~a & mask;
            4'd5:  e.res = a & b;
            4'd6:  e.res = a | b;
            4'd7:  e.res = a ^ b;
            4'd8:  e.res = (a < b) ? 1 : 0;
            4'd9:  e.res = (a > b) ? 1 : 0;
            4'd10: e.z   = (a == b);
            4'd11: e.z   = (a != b);
            4'd12: e.res = a >> 1;
            4'd13: e.res = (a << 1) & mask;
            default: ;
        endcase
    endfunction

    // Wait for BUSY low, present one request and push its expected response
    task automatic issue(input int inst, input logic [3:0] op,
                         input longint unsigned a, input longint unsigned b);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (m_busy[inst] && n < 200) begin
            start32 = 1'b0;
            start8  = 1'b0;
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("busy_timeout", 64'd1, 64'd0);
        if (inst == 0) begin
            start32 = 1'b1; op32 = op; a32 = 32'(a); b32 = 32'(b); start8 = 1'b0;
        end else begin
            start8 = 1'b1; op8 = op; a8 = 8'(a); b8 = 8'(b); start32 = 1'b0;
        end
        ref_model(widths[inst], op, a, b, e);
        e.inst       = inst;
        e.start_edge = cyc + 1;
        e.done_edge  = e.multi ? cyc + 2 + longint'(widths[inst]) : cyc + 1;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        start32 = 1'b0;
        start8  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 500) begin
            idle();
            n++;
        end
        if (q.size() > 0) check("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic rand_ops(input int inst, input int count);
        longint unsigned mask, a, b;
        logic [3:0] op;
        mask = (64'd1 << widths[inst]) - 64'd1;
        for (int i = 0; i < count; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom % 4 == 0) ? 64'($urandom_range(0, 15)) : (64'($urandom) & mask);
            b  = ($urandom % 4 == 0) ? 64'($urandom_range(0, 15)) : (64'($urandom) & mask);
            if ($urandom % 5 == 0) b = 0;
            if ($urandom % 6 == 0) b = a;
            issue(inst, op, a, b);
            if ($urandom % 3 == 0) idle();
        end
    endtask

    // Monitor: pop and compare on DONE, otherwise outputs must hold; also BUSY window and DONE deadline
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (m_done[i]) begin
                    if (q.size() == 0 || q[0].inst != i) begin
                        check($sformatf("spurious_done%0d", i), 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("resultado", m_res[i], e.res);
                        check("restodiv", m_rem[i], e.rem);
                        check("zero", 64'(m_z[i]), 64'(e.z));
                        check("div0", 64'(m_d0[i]), 64'(e.d0));
                        check("done_edge", 64'(cyc), 64'(e.done_edge));
                        check("busy_at_done", 64'(m_busy[i]), 64'd0);
                        lst_res[i]   = e.res;
                        lst_rem[i]   = e.rem;
                        lst_flags[i] = {e.z, e.d0};
                    end
                end else begin
                    check("hold_res", m_res[i], lst_res[i]);
                    check("hold_rem", m_rem[i], lst_rem[i]);
                    check("hold_flags", 64'({m_z[i], m_d0[i]}), 64'(lst_flags[i]));
                end
            end
            if (q.size() > 0) begin
                if (q[0].multi && cyc >= q[0].start_edge &&
                    cyc < q[0].start_edge + longint'(widths[q[0].inst]))
                    check("busy_high", 64'(m_busy[q[0].inst]), 64'd1);
                if (cyc > q[0].done_edge) begin
                    check("done_missing", 64'(cyc), 64'(q[0].done_edge));
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
        for (int i = 0; i < 2; i++) begin
            lst_res[i] = '0; lst_rem[i] = '0; lst_flags[i] = '0;
        end
        #3;
        for (int i = 0; i < 2; i++) begin
            check("reset_res", m_res[i], 64'd0);
            check("reset_rem", m_rem[i], 64'd0);
            check("reset_flags", 64'({m_z[i], m_d0[i], m_busy[i], m_done[i]}), 64'd0);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed 32-bit cases
        issue(0, 4'd0, 5, 7);
        issue(0, 4'd1, 3, 5);
        issue(0, 4'd2, 64'hFFFF_FFFF, 2);
        issue(0, 4'd3, 100, 7);
        issue(0, 4'd3, 9, 0);
        issue(0, 4'd10, 4, 5);
        idle();

        // ADD pulsed mid-MUL must be ignored
        issue(0, 4'd2, 123456, 789);
        idle();
        repeat (9) @(negedge clk);
        start32 = 1'b1; op32 = 4'd0; a32 = 32'd1; b32 = 32'd1;
        idle();
        issue(0, 4'd10, 4, 4);
        issue(0, 4'd11, 4, 4);
        idle();

        // Reset mid-DIV aborts without DONE
        issue(0, 4'd3, 1000, 3);
        idle();
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lst_res[i] = '0; lst_rem[i] = '0; lst_flags[i] = '0;
        end
        #1;
        check("abort_res", m_res[0], 64'd0);
        check("abort_rem", m_rem[0], 64'd0);
        check("abort_flags", 64'({m_z[0], m_d0[0], m_busy[0], m_done[0]}), 64'd0);
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(0, 4'd8, 2, 3);
        issue(0, 4'd14, 77, 88);
        issue(0, 4'd15, 1, 1);

        rand_ops(0, 60);
        drain();

        // 8-bit instance
        issue(1, 4'd2, 8'hFF, 8'hFF);
        issue(1, 4'd13, 8'h81, 0);
        issue(1, 4'd3, 8'hFF, 8'h10);
        issue(1, 4'd0, 8'hF0, 8'h20);
        rand_ops(1, 30);
        drain();

        repeat (3) idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
